instr_sequencer: RTL and testbench

Multi-cycle fetch/decode/execute controller that drives the instruction decoder. It fetches a word over a req/ack instruction-memory handshake and holds it stable on `instr` for the decoder's two-stage registered latency. It then evaluates the condition field against the NZCV flags and issues one-cycle register-file and flag write strobes, data-memory transactions or PC redirects from the decoder's outputs. It sits between instruction memory, the decoder, the register file and data memory, and owns the program counter.

---
 rtl/instr_sequencer.sv | 225 ++++++++++++++++++++++
 tb/tb_instr_sequencer.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_sequencer.sv
// Fetch/decode/execute sequencer: fetches over a req/ack handshake, holds the word for the
// decoder, evaluates the NZCV condition and issues strobes, data accesses or PC redirects.
module instr_sequencer #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int          DEC_LAT  = 2
) (
   input  logic        clk,
   input  logic        rst_n,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ack,
   input  logic [31:0] imem_rdata,
   output logic [31:0] instr,
   input  logic [3:0]  flag,
   input  logic [1:0]  dec_op,
   input  logic        dec_write_data,
   input  logic        dec_flag_en,
   input  logic        dec_memory_data,
   input  logic        dec_memdata,
   input  logic [23:0] dec_imminstr,
   output logic        dmem_req,
   output logic        dmem_we,
   input  logic        dmem_ack,
   output logic        rf_we,
   output logic        flag_we,
   output logic [31:0] pc,
   output logic        halted
);

   localparam int CNT_W = (DEC_LAT > 1) ? $clog2(DEC_LAT) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEC_LAT - 1);

   typedef enum logic [2:0] {
      ST_FETCH  = 3'd0,
      ST_DECODE = 3'd1,
      ST_EXEC   = 3'd2,
      ST_MEM    = 3'd3,
      ST_HALT   = 3'd4
   } state_t;

   // Condition codes over NZCV; code 15 never executes.
   function automatic logic cond_pass(input logic [3:0] cond, input logic [3:0] nzcv);
      logic n, z, c, v, pass;
      n = nzcv[3];
      z = nzcv[2];
      c = nzcv[1];
      v = nzcv[0];
      case (cond)
         4'd0:    pass = z;
         4'd1:    pass = !z;
         4'd2:    pass = c;
         4'd3:    pass = !c;
         4'd4:    pass = n;
         4'd5:    pass = !n;
         4'd6:    pass = v;
         4'd7:    pass = !v;
         4'd8:    pass = c && !z;
         4'd9:    pass = !c || z;
         4'd10:   pass = (n == v);
         4'd11:   pass = (n != v);
         4'd12:   pass = !z && (n == v);
         4'd13:   pass = z || (n != v);
         4'd14:   pass = 1'b1;
         default: pass = 1'b0;
      endcase
      return pass;
   endfunction

   state_t           state_r, next_state_s;
   logic [CNT_W-1:0] cnt_r, cnt_s;
   logic [31:0]      pc_r, pc_s, instr_r, instr_s;
   logic             imem_req_r, imem_req_s, dmem_req_r, dmem_req_s, dmem_we_r, dmem_we_s;
   logic             rf_we_r, rf_we_s, flag_we_r, flag_we_s, halted_r, halted_s;
   logic             cond_ok_s, fetch_done_s, mem_done_s, mem_op_s;
   logic [31:0]      pc_inc_s, br_target_s;

   assign cond_ok_s    = cond_pass(instr_r[31:28], flag);
   assign fetch_done_s = imem_req_r && imem_ack;
   assign mem_done_s   = dmem_req_r && dmem_ack;
   assign mem_op_s     = dec_memory_data || dec_memdata;
   assign pc_inc_s     = pc_r + 32'd4;
   assign br_target_s  = pc_r + 32'd8 + {{6{dec_imminstr[23]}}, dec_imminstr, 2'b00};

   // State register and decode-latency counter.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r <= ST_FETCH;
         cnt_r   <= '0;
      end else begin
         state_r <= next_state_s;
         cnt_r   <= cnt_s;
      end
   end

   // Next-state logic.
   always_comb begin
      next_state_s = state_r;
      case (state_r)
         ST_FETCH:  next_state_s = fetch_done_s ? ST_DECODE : ST_FETCH;
         ST_DECODE: next_state_s = (cnt_r == CNT_LAST) ? ST_EXEC : ST_DECODE;
         ST_EXEC: begin
            if (!cond_ok_s) begin
               next_state_s = ST_FETCH;
            end else begin
               case (dec_op)
                  2'd1:    next_state_s = mem_op_s ? ST_MEM : ST_FETCH;
                  2'd3:    next_state_s = ST_HALT;
                  default: next_state_s = ST_FETCH;
               endcase
            end
         end
         ST_MEM:    next_state_s = mem_done_s ? ST_FETCH : ST_MEM;
         ST_HALT:   next_state_s = ST_HALT;
         default:   next_state_s = ST_FETCH;
      endcase
   end

   // Next values of the registered outputs; every redirect back to FETCH raises imem_req at once.
   always_comb begin
      cnt_s      = cnt_r;
      pc_s       = pc_r;
      instr_s    = instr_r;
      imem_req_s = 1'b0;
      dmem_req_s = 1'b0;
      dmem_we_s  = dmem_we_r;
      rf_we_s    = 1'b0;
      flag_we_s  = 1'b0;
      halted_s   = 1'b0;
      case (state_r)
         ST_FETCH: begin
            if (fetch_done_s) begin
               instr_s = imem_rdata;
               cnt_s   = '0;
            end else begin
               imem_req_s = 1'b1;
            end
         end
         ST_DECODE: begin
            if (cnt_r == CNT_LAST) begin
               cnt_s = cnt_r;
            end else begin
               cnt_s = cnt_r + 1'b1;
            end
         end
         ST_EXEC: begin
            if (!cond_ok_s) begin
               pc_s       = pc_inc_s;
               imem_req_s = 1'b1;
            end else begin
               case (dec_op)
                  2'd0: begin
                     rf_we_s    = dec_write_data;
                     flag_we_s  = dec_flag_en;
                     pc_s       = pc_inc_s;
                     imem_req_s = 1'b1;
                  end
                  2'd1: begin
                     if (mem_op_s) begin
                        dmem_req_s = 1'b1;
                        dmem_we_s  = dec_memdata;
                     end else begin
                        pc_s       = pc_inc_s;
                        imem_req_s = 1'b1;
                     end
                  end
                  2'd2: begin
                     pc_s       = br_target_s;
                     imem_req_s = 1'b1;
                  end
                  2'd3:    halted_s = 1'b1;
                  default: begin
                     pc_s       = pc_inc_s;
                     imem_req_s = 1'b1;
                  end
               endcase
            end
         end
         ST_MEM: begin
            if (mem_done_s) begin
               rf_we_s    = !dmem_we_r;
               pc_s       = pc_inc_s;
               imem_req_s = 1'b1;
            end else begin
               dmem_req_s = 1'b1;
            end
         end
         ST_HALT:  halted_s = 1'b1;
         default:  halted_s = 1'b0;
      endcase
   end

   // Output and datapath registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc_r       <= RESET_PC;
         instr_r    <= 32'h0000_0000;
         imem_req_r <= 1'b0;
         dmem_req_r <= 1'b0;
         dmem_we_r  <= 1'b0;
         rf_we_r    <= 1'b0;
         flag_we_r  <= 1'b0;
         halted_r   <= 1'b0;
      end else begin
         pc_r       <= pc_s;
         instr_r    <= instr_s;
         imem_req_r <= imem_req_s;
         dmem_req_r <= dmem_req_s;
         dmem_we_r  <= dmem_we_s;
         rf_we_r    <= rf_we_s;
         flag_we_r  <= flag_we_s;
         halted_r   <= halted_s;
      end
   end

   assign imem_req  = imem_req_r;
   assign imem_addr = pc_r;
   assign instr     = instr_r;
   assign dmem_req  = dmem_req_r;
   assign dmem_we   = dmem_we_r;
   assign rf_we     = rf_we_r;
   assign flag_we   = flag_we_r;
   assign pc        = pc_r;
   assign halted    = halted_r;

endmodule

// File: tb/tb_instr_sequencer.sv
// Directed bench for instr_sequencer: a driver plays instruction memory, decoder and data
// memory from a vector table and queues expected events; a monitor pops and compares them.
module tb_instr_sequencer;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        imem_req, imem_ack = 1'b0;
   logic [31:0] imem_addr, imem_rdata = 32'h0, instr, pc;
   logic [3:0]  flag = 4'h0;
   logic [1:0]  dec_op = 2'd0;
   logic        dec_write_data = 1'b0, dec_flag_en = 1'b0, dec_memory_data = 1'b0, dec_memdata = 1'b0;
   logic [23:0] dec_imminstr = 24'h0;
   logic        dmem_req, dmem_we, dmem_ack = 1'b0, rf_we, flag_we, halted;

   instr_sequencer #(.RESET_PC(32'h0000_0000), .DEC_LAT(2)) dut (
      .clk(clk), .rst_n(rst_n),
      .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
      .instr(instr), .flag(flag), .dec_op(dec_op),
      .dec_write_data(dec_write_data), .dec_flag_en(dec_flag_en),
      .dec_memory_data(dec_memory_data), .dec_memdata(dec_memdata), .dec_imminstr(dec_imminstr),
      .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_ack(dmem_ack),
      .rf_we(rf_we), .flag_we(flag_we), .pc(pc), .halted(halted)
   );

   always #5 clk = ~clk;

   // kind 0: fetch start {a=addr, b={rf_we,flag_we}, ival=cycles since previous fetch start or -1}
   // kind 1: data access complete {a=dmem_we, b=cycles dmem_req was high}
   typedef struct {
      int          kind;
      logic [31:0] a;
      logic [31:0] b;
      int          ival;
   } exp_t;

   typedef struct {
      logic [3:0]  cnd;
      logic [3:0]  flg;
      logic [1:0]  op;
      logic        wd, fe, ld, st;
      logic [23:0] imm;
      int          iw, dw;
      logic [31:0] nxt;
      logic        erf, efl, mem, mwe;
      int          ival;
      logic        quiet;
   } vec_t;

   exp_t q[$];
   vec_t vt[$];
   int   total = 0;
   int   bad = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic finish_tb();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   endtask

   task automatic timeout(input string what);
      total++;
      bad++;
      $display("FAIL timeout waiting for %s at %0t", what, $time);
      finish_tb();
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic vec_t mk(input logic [3:0] cnd, input logic [3:0] flg, input logic [1:0] op,
                               input logic wd, input logic fe, input logic ld, input logic st,
                               input logic [23:0] imm, input int iw, input int dw,
                               input logic [31:0] nxt, input logic erf, input logic efl,
                               input logic mem, input int ival, input logic quiet);
      vec_t v;
      v.cnd = cnd; v.flg = flg; v.op = op; v.wd = wd; v.fe = fe; v.ld = ld; v.st = st;
      v.imm = imm; v.iw = iw; v.dw = dw; v.nxt = nxt; v.erf = erf; v.efl = efl;
      v.mem = mem; v.mwe = st; v.ival = ival; v.quiet = quiet;
      return v;
   endfunction

   task automatic push_fetch(input logic [31:0] addr, input logic erf, input logic efl, input int ival);
      exp_t e;
      e.kind = 0; e.a = addr; e.b = {30'd0, erf, efl}; e.ival = ival;
      q.push_back(e);
   endtask

   task automatic run_vec(input vec_t v);
      int          n;
      logic [31:0] word;
      exp_t        e;
      word = {v.cnd, 4'hA, v.imm};
      n = 0;
      while (!imem_req && n < 100) begin
         step();
         n++;
      end
      if (!imem_req) timeout("imem_req");
      repeat (v.iw) step();
      imem_ack = 1'b1;
      imem_rdata = word;
      flag = v.flg;
      dec_op = v.op;
      dec_write_data = v.wd;
      dec_flag_en = v.fe;
      dec_memory_data = v.ld;
      dec_memdata = v.st;
      dec_imminstr = v.imm;
      if (!v.quiet) begin
         if (v.mem) begin
            e.kind = 1; e.a = {31'd0, v.mwe}; e.b = 32'(v.dw + 1); e.ival = -1;
            q.push_back(e);
         end
         push_fetch(v.nxt, v.erf, v.efl, v.ival);
      end
      step();
      imem_ack = 1'b0;
      check("instr_latched", instr, word);
      if (v.mem) begin
         n = 0;
         while (!dmem_req && n < 100) begin
            step();
            n++;
         end
         if (!dmem_req) timeout("dmem_req");
         repeat (v.dw) step();
         dmem_ack = 1'b1;
         step();
         dmem_ack = 1'b0;
      end
   endtask

   // Monitor: compares each fetch start and each completed data access with the queue head.
   initial begin : monitor
      logic        prev_req;
      logic [31:0] prev_addr;
      int          cyc, last_rise, dcnt;
      exp_t        e;
      prev_req = 1'b0; prev_addr = 32'h0; cyc = 0; last_rise = 0; dcnt = 0;
      forever begin
         @(negedge clk);
         cyc++;
         if (!rst_n) begin
            prev_req = 1'b0;
            dcnt = 0;
         end else begin
            if (imem_req && !prev_req) begin
               if (q.size() == 0) begin
                  check("unexpected_fetch_addr", imem_addr, 32'hxxxx_xxxx);
               end else begin
                  e = q.pop_front();
                  check("event_kind_fetch", 32'(e.kind), 32'd0);
                  check("fetch_addr", imem_addr, e.a);
                  check("strobes_rf_flag", {30'd0, rf_we, flag_we}, e.b);
                  if (e.ival >= 0) check("instr_cycles", 32'(cyc - last_rise), 32'(e.ival));
               end
               last_rise = cyc;
            end else if (rf_we || flag_we) begin
               check("stray_strobe", {30'd0, rf_we, flag_we}, 32'd0);
            end
            if (imem_req && prev_req) check("imem_addr_stable", imem_addr, prev_addr);
            if (dmem_req) dcnt++;
            else dcnt = 0;
            if (dmem_req && dmem_ack) begin
               if (q.size() == 0) begin
                  check("unexpected_dmem_cycles", 32'(dcnt), 32'hxxxx_xxxx);
               end else begin
                  e = q.pop_front();
                  check("event_kind_dmem", 32'(e.kind), 32'd1);
                  check("dmem_we", {31'd0, dmem_we}, e.a);
                  check("dmem_req_cycles", 32'(dcnt), e.b);
               end
            end
            prev_req = imem_req;
            prev_addr = imem_addr;
         end
      end
   end

   initial begin : driver
      int n;
      //              cnd   flg   op   wd fe ld st imm        iw dw nxt           rf fl mem ival quiet
      vt.push_back(mk(4'hE, 4'h0, 2'd0, 1, 1, 0, 0, 24'h000000, 0, 0, 32'h0000_0004, 1, 1, 0, 4, 0));
      vt.push_back(mk(4'h0, 4'h0, 2'd0, 1, 1, 0, 0, 24'h000000, 0, 0, 32'h0000_0008, 0, 0, 0, 4, 0));
      vt.push_back(mk(4'h0, 4'h4, 2'd0, 1, 0, 0, 0, 24'h000000, 2, 0, 32'h0000_000C, 1, 0, 0, 6, 0));
      vt.push_back(mk(4'hE, 4'h0, 2'd1, 0, 0, 1, 0, 24'h000000, 0, 3, 32'h0000_0010, 1, 0, 1, 8, 0));
      vt.push_back(mk(4'hE, 4'h0, 2'd1, 1, 1, 0, 1, 24'h000000, 1, 0, 32'h0000_0014, 0, 0, 1, 6, 0));
      vt.push_back(mk(4'hE, 4'h0, 2'd1, 1, 1, 0, 0, 24'h000000, 0, 0, 32'h0000_0018, 0, 0, 0, 4, 0));
      vt.push_back(mk(4'hC, 4'h9, 2'd0, 0, 1, 0, 0, 24'h000000, 0, 0, 32'h0000_001C, 0, 1, 0, 4, 0));
      vt.push_back(mk(4'hB, 4'h9, 2'd0, 1, 1, 0, 0, 24'h000000, 0, 0, 32'h0000_0020, 0, 0, 0, 4, 0));
      vt.push_back(mk(4'hF, 4'h0, 2'd2, 0, 0, 0, 0, 24'h000040, 0, 0, 32'h0000_0024, 0, 0, 0, 4, 0));
      vt.push_back(mk(4'hE, 4'h0, 2'd2, 0, 0, 0, 0, 24'h000035, 0, 0, 32'h0000_0100, 0, 0, 0, 4, 0));
      vt.push_back(mk(4'hE, 4'h0, 2'd2, 0, 0, 0, 0, 24'hFFFFFE, 0, 0, 32'h0000_0100, 0, 0, 0, 4, 0));
      vt.push_back(mk(4'hE, 4'h0, 2'd2, 0, 0, 0, 0, 24'hFFFFBC, 0, 0, 32'hFFFF_FFF8, 0, 0, 0, 4, 0));
      vt.push_back(mk(4'hE, 4'h0, 2'd2, 0, 0, 0, 0, 24'h000001, 0, 0, 32'h0000_0004, 0, 0, 0, 4, 0));
      vt.push_back(mk(4'h8, 4'h2, 2'd0, 1, 1, 0, 0, 24'h000000, 0, 0, 32'h0000_0008, 1, 1, 0, 4, 0));
      vt.push_back(mk(4'h2, 4'h0, 2'd3, 0, 0, 0, 0, 24'h000000, 0, 0, 32'h0000_000C, 0, 0, 0, 4, 0));
      vt.push_back(mk(4'hE, 4'h0, 2'd3, 0, 0, 0, 0, 24'h000000, 0, 0, 32'h0000_0000, 0, 0, 0, 4, 1));

      repeat (3) step();
      check("rst_pc", pc, 32'h0000_0000);
      check("rst_instr", instr, 32'h0000_0000);
      check("rst_imem_req", {31'd0, imem_req}, 32'd0);
      check("rst_dmem_req", {31'd0, dmem_req}, 32'd0);
      check("rst_dmem_we", {31'd0, dmem_we}, 32'd0);
      check("rst_rf_we", {31'd0, rf_we}, 32'd0);
      check("rst_flag_we", {31'd0, flag_we}, 32'd0);
      check("rst_halted", {31'd0, halted}, 32'd0);

      push_fetch(32'h0000_0000, 1'b0, 1'b0, -1);
      rst_n = 1'b1;
      step();
      check("req_after_release", {31'd0, imem_req}, 32'd1);

      foreach (vt[i]) run_vec(vt[i]);

      n = 0;
      while (!halted && n < 20) begin
         step();
         n++;
      end
      check("halted", {31'd0, halted}, 32'd1);
      n = 0;
      for (int i = 0; i < 20; i++) begin
         step();
         if (imem_req || dmem_req) n++;
      end
      check("halt_req_cycles", 32'(n), 32'd0);

      rst_n = 1'b0;
      #1;
      check("halt_cleared_by_reset", {31'd0, halted}, 32'd0);
      step();
      push_fetch(32'h0000_0000, 1'b0, 1'b0, -1);
      rst_n = 1'b1;
      step();

      run_vec(mk(4'hE, 4'h0, 2'd1, 1, 0, 1, 0, 24'h000000, 0, 0, 32'h0, 0, 0, 0, -1, 1));
      n = 0;
      while (!dmem_req && n < 100) begin
         step();
         n++;
      end
      if (!dmem_req) timeout("dmem_req before reset");
      repeat (2) step();
      check("dmem_req_waiting", {31'd0, dmem_req}, 32'd1);
      #2;
      rst_n = 1'b0;
      #1;
      check("async_dmem_req_drop", {31'd0, dmem_req}, 32'd0);
      check("async_pc_reset", pc, 32'h0000_0000);
      step();
      step();
      push_fetch(32'h0000_0000, 1'b0, 1'b0, -1);
      rst_n = 1'b1;
      step();
      check("refetch_req", {31'd0, imem_req}, 32'd1);

      run_vec(mk(4'hE, 4'h0, 2'd0, 1, 0, 0, 0, 24'h000000, 0, 0, 32'h0000_0004, 1, 0, 0, 4, 0));
      n = 0;
      while (q.size() != 0 && n < 50) begin
         step();
         n++;
      end
      if (q.size() != 0) timeout("queued events");
      step();
      finish_tb();
   end

endmodule
